para_shape_sched: RTL and testbench

PARA_SHAPE_SCHED -- requirements
Module: para_shape_sched

---
 rtl/para_shape_sched_pkg.sv | 33 +++
 rtl/para_shape_sched_hit.sv | 44 ++++
 rtl/para_shape_sched.sv | 175 +++++++++++++++++
 tb/tb_para_shape_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/para_shape_sched_pkg.sv
// Shared types for the parallelogram shape scheduler: FSM state, coordinate
// type and the per-slot configuration record.
package para_shape_sched_pkg;

    localparam int COORD_W = 11;
    // Hit arithmetic runs two bits wider so offset + origin + width never wraps.
    localparam int ARITH_W = 13;
    // Colour storage width in the slot record; the top module uses the low CW bits.
    localparam int CW_MAX  = 16;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ARITH_W-1:0] arith_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic              en;
        coord_t            cx;
        coord_t            cy;
        coord_t            width;
        coord_t            height;
        logic [CW_MAX-1:0] color;
    } slot_t;

    function automatic arith_t zext(input coord_t v);
        return {{(ARITH_W-COORD_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/para_shape_sched_hit.sv
// Combinational parallelogram hit test: strict comparisons on all four edges,
// with rows sheared right by (y - cy).
module para_hit_unit
    import para_shape_sched_pkg::*;
(
    input  coord_t x,
    input  coord_t y,
    input  coord_t cx,
    input  coord_t cy,
    input  coord_t width,
    input  coord_t height,
    input  logic   en,
    output logic   hit
);

    arith_t x_w;
    arith_t y_w;
    arith_t cy_w;
    arith_t bottom_w;
    arith_t dy_w;
    arith_t left_w;
    arith_t right_w;
    logic   y_above;
    logic   y_below;
    logic   x_right_of;
    logic   x_left_of;

    always_comb begin
        x_w      = zext(x);
        y_w      = zext(y);
        cy_w     = zext(cy);
        bottom_w = cy_w + zext(height);
        y_above  = y_w > cy_w;
        y_below  = y_w < bottom_w;
        // The row offset is only meaningful above the base row; avoid underflow.
        dy_w       = y_above ? (y_w - cy_w) : '0;
        left_w     = dy_w + zext(cx);
        right_w    = left_w + zext(width);
        x_right_of = x_w > left_w;
        x_left_of  = x_w < right_w;
        hit        = en & y_above & y_below & x_right_of & x_left_of;
    end

endmodule

// File: rtl/para_shape_sched.sv
// Sequential shape scheduler: scans NSLOT configured parallelograms one per
// cycle through a single hit unit and reports the lowest-index hit or background.
module para_shape_sched
    import para_shape_sched_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    output logic                     cfg_ready,
    input  logic [$clog2(NSLOT)-1:0] cfg_idx,
    input  logic                     cfg_en,
    input  logic [10:0]              cfg_cx,
    input  logic [10:0]              cfg_cy,
    input  logic [10:0]              cfg_width,
    input  logic [10:0]              cfg_height,
    input  logic [CW-1:0]            cfg_color,
    input  logic [CW-1:0]            bg_color,
    input  logic                     px_valid,
    output logic                     px_ready,
    input  logic [10:0]              px_x,
    input  logic [10:0]              px_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_hit,
    output logic [$clog2(NSLOT)-1:0] out_slot,
    output logic [CW-1:0]            out_color
);

    localparam int IW = $clog2(NSLOT);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLOT - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    coord_t            px_x_q, px_x_d;
    coord_t            px_y_q, px_y_d;
    logic              out_valid_q, out_valid_d;
    logic              out_hit_q, out_hit_d;
    logic [IW-1:0]     out_slot_q, out_slot_d;
    logic [CW-1:0]     out_color_q, out_color_d;

    slot_t             slot_q [NSLOT];
    slot_t             slot_d [NSLOT];
    slot_t             new_slot;
    slot_t             cur_slot;
    logic [CW_MAX-1:0] cfg_color_ext;
    logic              is_idle;
    logic              cfg_wr;
    logic              px_acc;
    logic              slot_hit;
    logic              color_unused;

    assign is_idle   = (state_q == ST_IDLE);
    assign cfg_ready = is_idle;
    assign px_ready  = is_idle;
    assign cfg_wr    = cfg_we & is_idle;
    assign px_acc    = px_valid & is_idle;

    always_comb begin
        cfg_color_ext         = '0;
        cfg_color_ext[CW-1:0] = cfg_color;
    end

    always_comb begin
        new_slot.en     = cfg_en;
        new_slot.cx     = cfg_cx;
        new_slot.cy     = cfg_cy;
        new_slot.width  = cfg_width;
        new_slot.height = cfg_height;
        new_slot.color  = cfg_color_ext;
    end

    // Writes land at the accept edge, so a same-cycle pixel scans the new table.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        assign slot_d[gi] = (cfg_wr && (cfg_idx == IW'(gi))) ? new_slot : slot_q[gi];
    end

    assign cur_slot     = slot_q[cnt_q];
    assign color_unused = ^cur_slot.color;

    para_hit_unit u_hit (
        .x      (px_x_q),
        .y      (px_y_q),
        .cx     (cur_slot.cx),
        .cy     (cur_slot.cy),
        .width  (cur_slot.width),
        .height (cur_slot.height),
        .en     (cur_slot.en),
        .hit    (slot_hit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        px_x_d      = px_x_q;
        px_y_d      = px_y_q;
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_slot_d  = out_slot_q;
        out_color_d = out_color_q;
        case (state_q)
            ST_IDLE: begin
                if (px_acc) begin
                    px_x_d  = px_x;
                    px_y_d  = px_y;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (slot_hit) begin
                    out_valid_d = 1'b1;
                    out_hit_d   = 1'b1;
                    out_slot_d  = cnt_q;
                    out_color_d = cur_slot.color[CW-1:0];
                    state_d     = ST_DONE;
                end else if (cnt_q == LAST_IDX) begin
                    out_valid_d = 1'b1;
                    out_hit_d   = 1'b0;
                    out_slot_d  = '0;
                    out_color_d = bg_color;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            px_x_q      <= '0;
            px_y_q      <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_slot_q  <= '0;
            out_color_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            px_x_q      <= px_x_d;
            px_y_q      <= px_y_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_slot_q  <= out_slot_d;
            out_color_q <= out_color_d;
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_slot  = out_slot_q;
    assign out_color = out_color_q;

endmodule

// File: tb/tb_para_shape_sched.sv
// Scoreboard bench for para_shape_sched: the driver queues expected results,
// a negedge monitor checks latency, values, stability and handshake gating.
module tb_para_shape_sched;

    localparam int NSLOT = 4;
    localparam int CW    = 8;
    localparam int IW    = 2;
    localparam logic [CW-1:0] BG = 8'h5A;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic          cfg_ready;
    logic [IW-1:0] cfg_idx;
    logic          cfg_en;
    logic [10:0]   cfg_cx, cfg_cy, cfg_width, cfg_height;
    logic [CW-1:0] cfg_color;
    logic [CW-1:0] bg_color;
    logic          px_valid;
    logic          px_ready;
    logic [10:0]   px_x, px_y;
    logic          out_valid;
    logic          out_ready;
    logic          out_hit;
    logic [IW-1:0] out_slot;
    logic [CW-1:0] out_color;

    para_shape_sched #(.NSLOT(NSLOT), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_cx     (cfg_cx),
        .cfg_cy     (cfg_cy),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_color  (cfg_color),
        .bg_color   (bg_color),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hit    (out_hit),
        .out_slot   (out_slot),
        .out_color  (out_color)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [IW-1:0] slot;
        logic [CW-1:0] color;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc        = 0;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the head of the queue whenever a result is presented.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                if (!prev_valid) chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                chk("out_hit", out_hit, exp_q[0].hit);
                chk("out_slot", out_slot, exp_q[0].slot);
                chk("out_color", out_color, exp_q[0].color);
                chk("px_ready_in_done", px_ready, 0);
                chk("cfg_ready_in_done", cfg_ready, 0);
                if (out_ready) begin
                    $display("result hit=%0d slot=%0d color=%0h at cycle %0d",
                             out_hit, out_slot, out_color, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_valid = rst && out_valid;
    end

    task automatic wait_idle();
        for (int i = 0; i < 50 && !px_ready; i++) @(posedge clk) #1;
        if (!px_ready) chk("idle_timeout", px_ready, 1);
    endtask

    task automatic set_cfg(input logic [IW-1:0] idx, input logic en, input int cx, input int cy,
                           input int w, input int h, input logic [CW-1:0] col);
        cfg_idx    = idx;
        cfg_en     = en;
        cfg_cx     = 11'(cx);
        cfg_cy     = 11'(cy);
        cfg_width  = 11'(w);
        cfg_height = 11'(h);
        cfg_color  = col;
    endtask

    task automatic write_slot(input logic [IW-1:0] idx, input logic en, input int cx, input int cy,
                              input int w, input int h, input logic [CW-1:0] col);
        wait_idle();
        set_cfg(idx, en, cx, cy, w, h, col);
        cfg_we = 1'b1;
        @(posedge clk) #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_px(input int x, input int y, input logic hit, input logic [IW-1:0] slot,
                           input logic [CW-1:0] col, input int lat, input int hold,
                           input bit cfg_same, input bit cfg_in_scan);
        exp_t e;
        wait_idle();
        px_x      = 11'(x);
        px_y      = 11'(y);
        px_valid  = 1'b1;
        cfg_we    = cfg_same;
        out_ready = (hold == 0);
        e = '{hit, slot, col, lat, cyc + 1};
        exp_q.push_back(e);
        $display("issue px=(%0d,%0d) expect hit=%0d slot=%0d color=%0h lat=%0d",
                 x, y, hit, slot, col, lat);
        @(posedge clk) #1;
        px_valid = 1'b0;
        cfg_we   = 1'b0;
        if (cfg_in_scan) begin
            cfg_we = 1'b1;
            @(posedge clk) #1;
            cfg_we = 1'b0;
        end
        if (hold > 0) begin
            for (int i = 0; i < 50 && !out_valid; i++) @(posedge clk) #1;
            repeat (hold) @(posedge clk) #1;
            out_ready = 1'b1;
        end
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk) #1;
        if (exp_q.size() != 0) begin
            chk("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst        = 1'b0;
        cfg_we     = 1'b0;
        px_valid   = 1'b0;
        px_x       = '0;
        px_y       = '0;
        out_ready  = 1'b1;
        bg_color   = BG;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_slot", out_slot, 0);
        chk("rst_out_color", out_color, 0);
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        chk("post_rst_px_ready", px_ready, 1);
        chk("post_rst_cfg_ready", cfg_ready, 1);

        // Empty table: every slot disabled.
        send_px(120, 60, 0, 0, BG, NSLOT, 0, 0, 0);

        write_slot(0, 1, 100, 50, 40, 20, 8'h11);
        send_px(120, 60, 1, 0, 8'h11, 1, 0, 0, 0);
        send_px(110, 60, 0, 0, BG, NSLOT, 0, 0, 0);
        send_px(150, 60, 0, 0, BG, NSLOT, 0, 0, 0);
        send_px(120, 50, 0, 0, BG, NSLOT, 0, 0, 0);

        // Slot 2 is written in the same cycle the pixel is accepted.
        write_slot(0, 0, 100, 50, 40, 20, 8'h11);
        write_slot(1, 1, 100, 50, 40, 20, 8'h22);
        set_cfg(2, 1, 100, 50, 40, 20, 8'h33);
        send_px(120, 60, 1, 1, 8'h22, 2, 0, 1, 0);
        send_px(120, 60, 1, 1, 8'h22, 2, 3, 0, 0);
        write_slot(1, 0, 100, 50, 40, 20, 8'h22);
        send_px(120, 60, 1, 2, 8'h33, 3, 0, 0, 0);

        // Right edge lands at 4045: only correct without 11-bit wrap-around.
        write_slot(0, 1, 2040, 55, 2000, 20, 8'h44);
        set_cfg(0, 0, 0, 0, 0, 0, 8'h00);
        send_px(2047, 60, 1, 0, 8'h44, 1, 0, 0, 1);
        send_px(2047, 60, 1, 0, 8'h44, 1, 0, 0, 0);

        // Abort a scan with reset: no result may appear and the table clears.
        wait_idle();
        px_x     = 11'd2047;
        px_y     = 11'd60;
        px_valid = 1'b1;
        @(posedge clk) #1;
        px_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        chk("abort_px_ready", px_ready, 1);
        chk("abort_out_valid_after", out_valid, 0);
        send_px(2047, 60, 0, 0, BG, NSLOT, 0, 0, 0);

        repeat (3) @(posedge clk) #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
